// File: rtl/div_ctrl_pkg.sv
// Shared widths, state encodings and handshake constants for the divide sequencer.
package div_ctrl_pkg;

    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 64;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } div_state_e;

    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

    function automatic logic [REG_BUS-1:0] mag(input logic [REG_BUS-1:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// Iterative 32-step restoring divider for DIV/DIVU; stalls the pipeline and
// returns {remainder, quotient} for the HI/LO write path.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                      cpu_clk_50M,
    input  logic                      cpu_rst_n,
    input  logic                      div_start_i,
    input  logic                      div_signed_i,
    input  logic [REG_BUS-1:0]        div_src1_i,
    input  logic [REG_BUS-1:0]        div_src2_i,
    input  logic                      div_annul_i,
    output logic                      stall_req_o,
    output logic                      div_ready_o,
    output logic [DOUBLE_REG_BUS-1:0] div_res_o
);

    div_state_e         state;
    logic [4:0]         cnt;
    logic [64:0]        work;      // {rem[32:0], quo[31:0]}
    logic [REG_BUS-1:0] divisor;
    logic               neg_quo;
    logic               neg_rem;

    logic               issue;
    logic [64:0]        shifted;
    logic [64:0]        step;
    logic [32:0]        diff;
    logic [REG_BUS-1:0] quo_fix;
    logic [REG_BUS-1:0] rem_fix;

    assign issue = div_start_i & ~div_annul_i;

    always_comb begin
        shifted = {work[63:0], 1'b0};
        diff    = shifted[64:32] - {1'b0, divisor};
        step    = shifted;
        if (shifted[64:32] >= {1'b0, divisor})
            step = {diff, shifted[31:1], 1'b1};
        quo_fix = mag(step[31:0], neg_quo);
        rem_fix = mag(step[63:32], neg_rem);
    end

    // Combinational on start so the pipeline freezes in the issue cycle itself.
    assign stall_req_o = cpu_rst_n &
                         (((state == DIV_FREE) & issue) | (state == DIV_BYZERO) | (state == DIV_ON));
    assign div_ready_o = (state == DIV_END) ? DIV_READY : DIV_NOT_READY;

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state     <= DIV_FREE;
            cnt       <= 5'd0;
            work      <= 65'd0;
            divisor   <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            div_res_o <= '0;
        end else if (div_annul_i && state != DIV_FREE) begin
            state <= DIV_FREE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (issue) begin
                        cnt <= 5'd0;
                        if (div_src2_i == '0) begin
                            // Raw dividend parked in the quotient half; no sign fixup applies.
                            work    <= {33'd0, div_src1_i};
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= DIV_BYZERO;
                        end else begin
                            work    <= {33'd0, mag(div_src1_i, div_signed_i & div_src1_i[31])};
                            divisor <= mag(div_src2_i, div_signed_i & div_src2_i[31]);
                            neg_quo <= div_signed_i & (div_src1_i[31] ^ div_src2_i[31]);
                            neg_rem <= div_signed_i & div_src1_i[31];
                            state   <= DIV_ON;
                        end
                    end
                end
                DIV_BYZERO: begin
                    div_res_o <= {work[31:0], 32'hFFFF_FFFF};
                    state     <= DIV_END;
                end
                DIV_ON: begin
                    work <= step;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        div_res_o <= {rem_fix, quo_fix};
                        cnt       <= 5'd0;
                        state     <= DIV_END;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, results, divide-by-zero, annul and reset.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        annul;
    logic        stall;
    logic        ready;
    logic [63:0] res;

    int passed = 0;
    int total  = 0;

    div_ctrl dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .div_start_i (start),
        .div_signed_i(sgn),
        .div_src1_i  (src1),
        .div_src2_i  (src2),
        .div_annul_i (annul),
        .stall_req_o (stall),
        .div_ready_o (ready),
        .div_res_o   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a request so that the following clock period is the issue cycle T.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; sgn = s; src1 = a; src2 = b;
    endtask

    // Counts cycles from T until ready (bounded); lat = ready cycle offset from T.
    task automatic wait_ready(output int lat, output bit stall_all);
        lat = 0; stall_all = 1'b1;
        @(negedge clk);
        while (!ready && lat < 100) begin
            if (stall !== 1'b1) stall_all = 1'b0;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_req();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; src1 = '0; src2 = '0; annul = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || ready !== 1'b0 || res !== 64'd0 || dut.state !== DIV_FREE)
            $display("FAIL reset: stall=%b ready=%b res=%h state=%0d, want 0/0/0/FREE", stall, ready, res, dut.state);
        else passed++;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_divu();
        int lat; bit st;
        issue(1'b0, 32'd100, 32'd7);
        wait_ready(lat, st);
        total++;
        if (lat != 33 || !st) $display("FAIL divu_latency: lat=%0d stall_all=%b, want 33/1", lat, st);
        else passed++;
        total++;
        if (res !== {32'h2, 32'hE} || stall !== 1'b0)
            $display("FAIL divu_result: res=%h stall=%b, want 000000020000000e/0", res, stall);
        else passed++;
        release_req();
        @(negedge clk);
        total++;
        if (ready !== 1'b0 || stall !== 1'b0) $display("FAIL ready_pulse: ready=%b stall=%b, want 0/0", ready, stall);
        else passed++;
    endtask

    task automatic test_div_signed();
        int lat; bit st;
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_ready(lat, st);
        total++;
        if (lat != 33 || res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
            $display("FAIL div_neg: lat=%0d res=%h, want 33/fffffffffffffffd", lat, res);
        else passed++;
        release_req();
    endtask

    task automatic test_byzero();
        int lat; bit st;
        issue(1'b0, 32'h1234_5678, 32'd0);
        wait_ready(lat, st);
        total++;
        if (lat != 2 || !st) $display("FAIL byzero_latency: lat=%0d stall_all=%b, want 2/1", lat, st);
        else passed++;
        total++;
        if (res !== {32'h1234_5678, 32'hFFFF_FFFF} || stall !== 1'b0)
            $display("FAIL byzero_result: res=%h stall=%b, want 12345678ffffffff/0", res, stall);
        else passed++;
        release_req();
    endtask

    task automatic test_overflow();
        int lat; bit st;
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_ready(lat, st);
        total++;
        if (lat != 33 || res !== {32'h0, 32'h8000_0000})
            $display("FAIL div_overflow: lat=%0d res=%h, want 33/0000000080000000", lat, res);
        else passed++;
        release_req();
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_ready(lat, st);
        total++;
        if (lat != 33 || res !== {32'h8000_0000, 32'h0})
            $display("FAIL divu_big: lat=%0d res=%h, want 33/8000000000000000", lat, res);
        else passed++;
        release_req();
    endtask

    task automatic test_annul();
        int lat; bit st;
        bit seen_ready = 1'b0;
        issue(1'b0, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ready) seen_ready = 1'b1;
        end
        annul = 1'b1; start = 1'b0;            // cycle T+10
        @(posedge clk); #1; annul = 1'b0;      // cycle T+11
        @(negedge clk);
        total++;
        if (dut.state !== DIV_FREE || stall !== 1'b0 || ready !== 1'b0 || seen_ready)
            $display("FAIL annul: state=%0d stall=%b ready=%b seen_ready=%b, want FREE/0/0/0",
                     dut.state, stall, ready, seen_ready);
        else passed++;
        issue(1'b0, 32'd9, 32'd3);             // cycle T+12
        wait_ready(lat, st);
        total++;
        if (lat != 33 || res !== {32'd0, 32'd3})
            $display("FAIL annul_next: lat=%0d res=%h, want 33/0000000000000003", lat, res);
        else passed++;
        release_req();
    endtask

    task automatic test_annul_with_start();
        @(posedge clk); #1;
        start = 1'b1; annul = 1'b1; sgn = 1'b0; src1 = 32'd50; src2 = 32'd5;
        @(negedge clk);
        total++;
        if (stall !== 1'b0) $display("FAIL annul_start_stall: stall=%b, want 0", stall);
        else passed++;
        @(posedge clk); #1; start = 1'b0; annul = 1'b0;
        @(negedge clk);
        total++;
        if (dut.state !== DIV_FREE || ready !== 1'b0)
            $display("FAIL annul_start_state: state=%0d ready=%b, want FREE/0", dut.state, ready);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int lat; bit st;
        issue(1'b0, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1; rst_n = 1'b0; start = 1'b0;        // cycle T+5
        @(negedge clk);
        total++;
        if (stall !== 1'b0) $display("FAIL reset_stall: stall=%b, want 0", stall);
        else passed++;
        @(negedge clk);                        // cycle T+6
        total++;
        if (dut.state !== DIV_FREE || ready !== 1'b0 || res !== 64'd0 || stall !== 1'b0)
            $display("FAIL reset_mid: state=%0d ready=%b res=%h stall=%b, want FREE/0/0/0",
                     dut.state, ready, res, stall);
        else passed++;
        @(posedge clk); #1; rst_n = 1'b1;
        issue(1'b1, 32'hFFFF_FF9C, 32'd7);     // -100 / 7 -> q=-14, r=-2
        wait_ready(lat, st);
        total++;
        if (lat != 33 || res !== {32'hFFFF_FFFE, 32'hFFFF_FFF2})
            $display("FAIL after_reset: lat=%0d res=%h, want 33/fffffffefffffff2", lat, res);
        else passed++;
        release_req();
    endtask

    task automatic test_back_to_back();
        int lat; bit st;
        issue(1'b0, 32'd100, 32'd7);
        wait_ready(lat, st);
        total++;
        if (lat != 33 || res !== {32'h2, 32'hE})
            $display("FAIL b2b_first: lat=%0d res=%h, want 33/000000020000000e", lat, res);
        else passed++;
        issue(1'b0, 32'd9, 32'd3);             // start stays high into the cycle after END
        wait_ready(lat, st);
        total++;
        if (lat != 33 || !st || res !== {32'd0, 32'd3})
            $display("FAIL b2b_second: lat=%0d stall_all=%b res=%h, want 33/1/0000000000000003", lat, st, res);
        else passed++;
        release_req();
    endtask

    initial begin
        test_reset();
        test_divu();
        test_div_signed();
        test_byzero();
        test_overflow();
        test_annul();
        test_annul_with_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
